mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer that shares the single main-memory module between the instruction-cache miss path and the data-cache miss/write path inside `proc_hier`. It grants one requester at a time with round-robin tie-breaking and drives the memory's read/write strobes. It also waits out the memory's fixed access latency and returns data with a one-cycle done pulse. It also keeps per-port grant counters for the performance log, alongside the ICacheReq/DCacheReq counts.

## Interface
- `LAT`, 4, memory access latency in cycles (≥1): data valid `LAT` cycles after the issue cycle
- `AW`, 16, address width
- `DW`, 16, data width
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `i_req`  in  1  I-side read request; held until `i_done`
- `i_addr`  in  AW  I-side address; stable while `i_req`
- `i_done`  out  1  one-cycle completion pulse
- `i_data_out`  out  DW  read data, valid with `i_done` and held until next I completion
- `d_req`  in  1  D-side request; held until `d_done`
- `d_wr`  in  1  1 = write, 0 = read; stable while `d_req`
- `d_addr`  in  AW  D-side address
- `d_data_in`  in  DW  D-side write data
- `d_done`  out  1  one-cycle completion pulse
- `d_data_out`  out  DW  read data, valid with `d_done`; unchanged by writes
- `mem_rd`, `mem_wr`  out  1  one-cycle memory strobes
- `mem_addr`  out  AW  memory address, valid in issue cycle
- `mem_data_in`  out  DW  memory write data, valid in issue cycle
- `mem_data_out`  in  DW  memory read data
- `busy`  out  1  high in every state except IDLE
- `i_grant_cnt`, `d_grant_cnt`  out  16  grants issued per port, wrapping

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Owner register `own` is I or D.
- IDLE: no request → stay.
  - One request → latch owner, address, `d_wr`, and write data; go to ISSUE.
  - Both requests → grant the port opposite `last_grant`.
- ISSUE (1 cycle):
  - Assert `mem_rd` for an I access or a D read, or `mem_wr` for a D write.
  - Drive `mem_addr` and `mem_data_in` from the latched values.
  - Load the latency counter with `LAT-1`; go to WAIT.
- WAIT: decrement the counter each cycle.
  - At 0: if the access is a read, capture `mem_data_out` into the owner's data register.
  - Then go to DONE.
- DONE (1 cycle):
  - Pulse the owner's done signal.
  - Set `last_grant = own` and increment the owner's grant counter.
  - Go to IDLE.
- Requester protocol:
  - `req` must be low in the IDLE cycle that follows its done pulse.
  - A `req` still high at that point is treated as a new request.
- Requests are sampled only in IDLE. Requests arriving during ISSUE, WAIT or DONE wait; they are not dropped.
- All strobes are 0 outside ISSUE. `mem_addr` and `mem_data_in` are 0 outside ISSUE.

## Timing
- Request seen in IDLE at cycle t:
  - issue at t+1;
  - memory data valid at t+1+LAT;
  - done pulse at t+2+LAT (t+6 for LAT=4).
- Back-to-back with contention: the second grant occurs in the IDLE cycle t+3+LAT, and its issue is at t+4+LAT.
- Counters increment in the DONE cycle and wrap 0xFFFF→0x0000.
- Reset values:
  - state = IDLE, `last_grant` = I (so D wins the first tie);
  - all outputs 0;
  - counters 0;
  - data registers 0.
- Reset asserted mid-transaction:
  - immediate return to IDLE, outputs forced to 0;
  - no done pulse;
  - the in-flight memory access is abandoned.
- Simultaneous `i_req` and `d_req` rising in the same IDLE cycle resolve by the tie rule only. There is no fixed priority.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - owner encoding (`OWN_I = 0`, `OWN_D = 1`);
  - default `LAT`, `AW`, `DW`.
- Sub-module `arb_lat_counter`: a loadable down-counter with a zero flag, width `$clog2(LAT)+1`.
- Everything else lives in `mem_arbiter`.

## Test plan
- I read alone, `i_addr` = 0x0040, memory returns 0xBEEF, LAT=4, request at t → `mem_rd` = 1 and `mem_addr` = 0x0040 at t+1 only; `i_done` = 1 at t+6 with `i_data_out` = 0xBEEF; `i_grant_cnt` = 1.
- D write to 0x1000 with data 0x1234 → `mem_wr` = 1 and `mem_data_in` = 0x1234 at t+1; `d_done` at t+6; `d_data_out` unchanged (0); `mem_rd` never asserted.
- Both requests high from the first cycle after reset → D issues at t+1 and `d_done` at t+6; I is granted at t+7, issues at t+8, and `i_done` at t+13.
- Both requests high again immediately after the previous case → D is granted (last grant was I); the pattern alternates D, I, D over three rounds.
- `rst` pulsed during WAIT of an I read → `busy` = 0 and all outputs 0 asynchronously; no `i_done` pulse; counters 0; a new request after reset completes normally.
- Preload `d_grant_cnt` to 0xFFFF via 65535 D grants (or force) plus one more → the count wraps to 0x0000 while `i_grant_cnt` is unaffected.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter and its latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_LAT = 4;
  localparam int DEF_AW  = 16;
  localparam int DEF_DW  = 16;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the memory latency; saturates at zero.
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int CW  = $clog2(LAT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] loadVal,
  output logic          isZero
);

  logic [CW-1:0] countReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadVal;
    end else if (dec && (countReg != '0)) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign isZero = (countReg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the I-cache and
// D-cache miss paths; one access in flight, done pulse after the latency expires.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_data_out,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_data_in,
  output logic          d_done,
  output logic [DW-1:0] d_data_out,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy,
  output logic [15:0]   i_grant_cnt,
  output logic [15:0]   d_grant_cnt
);

  localparam int CW = $clog2(LAT) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

  arbState_t     stateReg, stateNext;
  owner_t        ownReg, lastGrantReg, pickOwn;
  logic [AW-1:0] addrReg;
  logic [DW-1:0] wdataReg, iDataReg, dDataReg;
  logic          wrReg;
  logic [15:0]   iGrantCntReg, dGrantCntReg;
  logic          cntLoad, cntDec, cntZero;
  logic          anyReq, pickD;

  // On a tie the port that did not win last time gets the memory.
  assign anyReq  = i_req | d_req;
  assign pickD   = d_req & (~i_req | (lastGrantReg == OWN_I));
  assign pickOwn = pickD ? OWN_D : OWN_I;

  arb_lat_counter #(.LAT(LAT), .CW(CW)) latCounter (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .dec    (cntDec),
    .loadVal(LOAD_VAL),
    .isZero (cntZero)
  );

  always_comb begin
    stateNext   = stateReg;
    cntLoad     = 1'b0;
    cntDec      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (anyReq) stateNext = ISSUE;
      end
      ISSUE: begin
        mem_rd      = ~wrReg;
        mem_wr      = wrReg;
        mem_addr    = addrReg;
        mem_data_in = wdataReg;
        cntLoad     = 1'b1;
        stateNext   = WAIT;
      end
      WAIT: begin
        if (cntZero) stateNext = DONE;
        else         cntDec    = 1'b1;
      end
      DONE: begin
        i_done    = (ownReg == OWN_I);
        d_done    = (ownReg == OWN_D);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= IDLE;
      ownReg       <= OWN_I;
      lastGrantReg <= OWN_I;
      addrReg      <= '0;
      wdataReg     <= '0;
      wrReg        <= 1'b0;
      iDataReg     <= '0;
      dDataReg     <= '0;
      iGrantCntReg <= '0;
      dGrantCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      if ((stateReg == IDLE) && anyReq) begin
        ownReg   <= pickOwn;
        addrReg  <= pickD ? d_addr : i_addr;
        wrReg    <= pickD & d_wr;
        wdataReg <= pickD ? d_data_in : '0;
      end
      // Memory data is valid in the last WAIT cycle; writes leave the data registers alone.
      if ((stateReg == WAIT) && cntZero && !wrReg) begin
        if (ownReg == OWN_D) dDataReg <= mem_data_out;
        else                 iDataReg <= mem_data_out;
      end
      if (stateReg == DONE) begin
        lastGrantReg <= ownReg;
        if (ownReg == OWN_D) dGrantCntReg <= dGrantCntReg + 16'd1;
        else                 iGrantCntReg <= iGrantCntReg + 16'd1;
      end
    end
  end

  assign busy        = (stateReg != IDLE);
  assign i_data_out  = iDataReg;
  assign d_data_out  = dDataReg;
  assign i_grant_cnt = iGrantCntReg;
  assign d_grant_cnt = dGrantCntReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-timeline model of the arbiter compared every cycle,
// plus directed literal checks for contention, reset abort, read/write and counter wrap.
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_data_in, mem_data_out;
  logic          i_done, d_done, mem_rd, mem_wr, busy;
  logic [DW-1:0] i_data_out, d_data_out, mem_data_in;
  logic [AW-1:0] mem_addr;
  logic [15:0]   i_grant_cnt, d_grant_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_done      (i_done),
    .i_data_out  (i_data_out),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_data_in   (d_data_in),
    .d_done      (d_done),
    .d_data_out  (d_data_out),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .busy        (busy),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mode  = 0;   // 0 manual, 1 re-request as soon as allowed, 2 random
  int iGap  = 0;
  int dGap  = 0;

  // Model: one transaction timeline anchored at its grant cycle g.
  int          g = -1;
  bit          mOwnD, mWr, mLastD;
  logic [15:0] mAddr, mWdata, mIData, mDData, mICnt, mDCnt;
  int          doneCyc[$];
  bit          doneOwnD[$];

  task automatic chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    g = -1; mOwnD = 0; mWr = 0; mLastD = 0;
    mAddr = 0; mWdata = 0; mIData = 0; mDData = 0; mICnt = 0; mDCnt = 0;
  endtask

  task automatic checkOutputs();
    bit iss, dn, act;
    iss = (g >= 0) && (cyc == g + 1);
    dn  = (g >= 0) && (cyc == g + 2 + LAT);
    act = (g >= 0) && (cyc > g) && (cyc <= g + 2 + LAT);
    chk1("busy", busy, act);
    chk1("mem_rd", mem_rd, iss && !mWr);
    chk1("mem_wr", mem_wr, iss && mWr);
    chk16("mem_addr", mem_addr, iss ? mAddr : 16'h0);
    chk16("mem_data_in", mem_data_in, iss ? mWdata : 16'h0);
    chk1("i_done", i_done, dn && !mOwnD);
    chk1("d_done", d_done, dn && mOwnD);
    chk16("i_data_out", i_data_out, mIData);
    chk16("d_data_out", d_data_out, mDData);
    chk16("i_grant_cnt", i_grant_cnt, mICnt);
    chk16("d_grant_cnt", d_grant_cnt, mDCnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutputs();
    if (i_done) begin
      doneCyc.push_back(cyc); doneOwnD.push_back(1'b0);
      $display("[TB] cycle %0d I done data=0x%0h icnt=%0d", cyc, i_data_out, i_grant_cnt);
    end
    if (d_done) begin
      doneCyc.push_back(cyc); doneOwnD.push_back(1'b1);
      $display("[TB] cycle %0d D done data=0x%0h dcnt=%0d", cyc, d_data_out, d_grant_cnt);
    end
  endtask

  // Requesters drop req in the IDLE cycle after their done, then re-request per mode.
  task automatic driveInputs();
    bit prevDone;
    prevDone = (g >= 0) && (cyc - 1 == g + 2 + LAT);
    if (prevDone && !mOwnD) begin
      i_req = 0;
      iGap  = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end else if (!i_req && mode != 0) begin
      if (iGap == 0) begin
        i_req  = 1;
        i_addr = (mode == 2) ? 16'($urandom) : 16'h0100;
      end else iGap--;
    end
    if (prevDone && mOwnD) begin
      d_req = 0;
      dGap  = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end else if (!d_req && mode != 0) begin
      if (dGap == 0) begin
        d_req     = 1;
        d_wr      = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        d_addr    = (mode == 2) ? 16'($urandom) : 16'h0200;
        d_data_in = d_wr ? 16'($urandom) : 16'h0;
      end else dGap--;
    end
    if (mode == 2) mem_data_out = 16'($urandom);
  endtask

  task automatic modelStep();
    if (g >= 0 && cyc == g + 1 + LAT && !mWr) begin
      if (mOwnD) mDData = mem_data_out;
      else       mIData = mem_data_out;
    end
    if (g >= 0 && cyc == g + 2 + LAT) begin
      if (mOwnD) mDCnt = mDCnt + 16'd1;
      else       mICnt = mICnt + 16'd1;
      mLastD = mOwnD;
    end
    if ((g < 0 || cyc >= g + 3 + LAT) && (i_req || d_req)) begin
      mOwnD  = d_req && (!i_req || !mLastD);
      g      = cyc;
      mAddr  = mOwnD ? d_addr : i_addr;
      mWr    = mOwnD && d_wr;
      mWdata = mOwnD ? d_data_in : 16'h0;
    end
  endtask

  task automatic runCycles(int n);
    repeat (n) begin
      tick();
      driveInputs();
      modelStep();
    end
  endtask

  initial begin
    int t;
    bit rdSeen;
    rst = 1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_data_in = 0; mem_data_out = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);
    chk16("rst_icnt", i_grant_cnt, 16'h0);
    chk16("rst_ddata", d_data_out, 16'h0);
    @(negedge clk);
    rst = 0;

    // Contention from the first cycle after reset: D first, then strict alternation.
    cyc  = 0;
    mode = 1;
    driveInputs();
    modelStep();
    runCycles(36);
    chk16("contention_done_count", 16'(doneCyc.size()), 16'd5);
    if (doneCyc.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk16("contention_done_cycle", 16'(doneCyc[k]), 16'(6 + 7 * k));
        chk1("contention_done_owner_d", doneOwnD[k], (k % 2) == 0);
      end
    end
    chk16("contention_icnt", i_grant_cnt, 16'd2);
    chk16("contention_dcnt", d_grant_cnt, 16'd3);

    mode = 2;
    runCycles(3000);
    mode = 0;
    runCycles(20);
    chk1("drained_idle", busy, 1'b0);

    // Reset during the WAIT of an I read abandons it without a done pulse.
    tick();
    i_req = 1; i_addr = 16'h0222; mem_data_out = 16'h5555;
    driveInputs();
    modelStep();
    runCycles(3);
    chk1("pre_reset_busy", busy, 1'b1);
    #2 rst = 1;
    #1;
    chk1("async_busy", busy, 1'b0);
    chk1("async_mem_rd", mem_rd, 1'b0);
    chk1("async_i_done", i_done, 1'b0);
    chk16("async_mem_addr", mem_addr, 16'h0);
    chk16("async_icnt", i_grant_cnt, 16'h0);
    chk16("async_dcnt", d_grant_cnt, 16'h0);
    chk16("async_idata", i_data_out, 16'h0);
    chk16("async_ddata", d_data_out, 16'h0);
    i_req = 0;
    @(posedge clk);
    #1;
    chk1("reset_no_i_done", i_done, 1'b0);
    @(negedge clk);
    rst = 0;
    modelReset();

    // I read alone after reset.
    cyc = 0;
    i_req = 1; i_addr = 16'h0040; mem_data_out = 16'hBEEF;
    driveInputs();
    modelStep();
    runCycles(1);
    chk1("iread_mem_rd_t1", mem_rd, 1'b1);
    chk16("iread_mem_addr_t1", mem_addr, 16'h0040);
    runCycles(4);
    chk1("iread_mem_rd_t5", mem_rd, 1'b0);
    runCycles(1);
    chk1("iread_i_done_t6", i_done, 1'b1);
    chk16("iread_data_t6", i_data_out, 16'hBEEF);
    runCycles(1);
    chk16("iread_icnt", i_grant_cnt, 16'd1);

    // D write alone.
    tick();
    d_req = 1; d_wr = 1; d_addr = 16'h1000; d_data_in = 16'h1234;
    driveInputs();
    modelStep();
    t = cyc;
    rdSeen = 0;
    for (int k = 1; k <= 7; k++) begin
      runCycles(1);
      rdSeen |= mem_rd;
      if (k == 1) begin
        chk1("dwrite_mem_wr_t1", mem_wr, 1'b1);
        chk16("dwrite_mem_data_in_t1", mem_data_in, 16'h1234);
        chk16("dwrite_mem_addr_t1", mem_addr, 16'h1000);
      end
      if (k == 6) begin
        chk1("dwrite_d_done_t6", d_done, 1'b1);
        chk16("dwrite_ddata_unchanged", d_data_out, 16'h0);
      end
    end
    chk1("dwrite_no_mem_rd", rdSeen, 1'b0);
    chk16("dwrite_dcnt", d_grant_cnt, 16'd1);
    chk16("dwrite_elapsed", 16'(cyc - t), 16'd7);

    // Counter wrap: preload the D grant count to its maximum, then one more D grant.
    force dut.dGrantCntReg = 16'hFFFF;
    #1;
    release dut.dGrantCntReg;
    mDCnt = 16'hFFFF;
    chk16("wrap_preload", d_grant_cnt, 16'hFFFF);
    tick();
    d_req = 1; d_wr = 0; d_addr = 16'h2000; d_data_in = 16'h0; mem_data_out = 16'h0A0A;
    driveInputs();
    modelStep();
    runCycles(8);
    chk16("wrap_dcnt", d_grant_cnt, 16'h0000);
    chk16("wrap_icnt", i_grant_cnt, 16'd1);
    chk16("wrap_ddata", d_data_out, 16'h0A0A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
